// File: rtl/clock_ctrl_pkg.sv
// Shared mode encodings and default divider constants for the clock sequencer.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_e;

    localparam int DEF_TICK_DIV    = 50_000_000;
    localparam int DEF_BLINK_DIV   = 25_000_000;
    localparam int DEF_REPEAT_DLY  = 25_000_000;
    localparam int DEF_REPEAT_RATE = 10_000_000;

    // Mode button cycles RUN -> SET_HOUR -> SET_MIN -> RUN.
    function automatic mode_e next_mode(input mode_e cur);
        case (cur)
            MODE_RUN:      return MODE_SET_HOUR;
            MODE_SET_HOUR: return MODE_SET_MIN;
            default:       return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a debounced button, with a registered one-cycle
// rising-edge pulse and the synchronized level.
module btn_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic pulse,
    output logic level
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            meta   <= btn;
            sync   <= meta;
            sync_d <= sync;
            pulse  <= sync & ~sync_d;
        end
    end

    assign level = sync;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Sequencer for the clock's BCD counter chain: 1 Hz tick, mode FSM driven by
// the mode/inc buttons, auto-repeat increment, stage enables and blink masks.
module clock_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int BLINK_DIV   = DEF_BLINK_DIV,
    parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
    parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       cd_sec,
    input  logic       cd_min,
    input  logic       cd_hour,
    output logic       en_sec,
    output logic       en_min,
    output logic       en_hour,
    output logic       en_day,
    output logic       sec_clr,
    output logic       blink_min,
    output logic       blink_hour,
    output logic [1:0] mode
);

    localparam int TICK_W   = $clog2(TICK_DIV);
    localparam int BLINK_W  = $clog2(BLINK_DIV);
    localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_DLY   = HOLD_W'(REPEAT_DLY);
    localparam logic [HOLD_W-1:0]  HOLD_RATE  = HOLD_W'(REPEAT_RATE);

    mode_e               state;
    logic [TICK_W-1:0]   presc;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                hold_act;
    logic                hold_repeating;

    logic mode_p;
    logic mode_lvl_unused;
    logic inc_p;
    logic inc_lvl;

    logic              in_run;
    logic              in_set;
    logic              tick;
    logic              rep_fire;
    logic              inc_evt;
    logic [HOLD_W-1:0] hold_target;

    btn_sync_edge u_mode_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_mode),
        .pulse   (mode_p),
        .level   (mode_lvl_unused)
    );

    btn_sync_edge u_inc_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_inc),
        .pulse   (inc_p),
        .level   (inc_lvl)
    );

    // reset_n gates the run path so carries cannot leak through while reset is held.
    always_comb begin
        in_run      = reset_n && (state == MODE_RUN);
        in_set      = (state != MODE_RUN);
        tick        = in_run && (presc == TICK_LAST);
        hold_target = hold_repeating ? HOLD_RATE : HOLD_DLY;
        rep_fire    = hold_act && inc_lvl && (hold_cnt == hold_target);
        inc_evt     = in_set && !mode_p && (inc_p || rep_fire);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= MODE_RUN;
            sec_clr <= 1'b0;
        end else begin
            sec_clr <= 1'b0;
            if (mode_p) begin
                state   <= next_mode(state);
                sec_clr <= (state == MODE_RUN);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if ((state != MODE_RUN) || mode_p) begin
            presc <= '0;
        end else if (presc == TICK_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // hold_cnt counts cycles since the press (or last repeat) while inc stays held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_act       <= 1'b0;
            hold_cnt       <= '0;
            hold_repeating <= 1'b0;
        end else if (mode_p || !in_set || !inc_lvl) begin
            hold_act       <= 1'b0;
            hold_cnt       <= '0;
            hold_repeating <= 1'b0;
        end else if (inc_p) begin
            hold_act       <= 1'b1;
            hold_cnt       <= HOLD_W'(1);
            hold_repeating <= 1'b0;
        end else if (hold_act) begin
            if (rep_fire) begin
                hold_cnt       <= HOLD_W'(1);
                hold_repeating <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // Restarting the blink on every increment keeps the edited field visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (mode_p || inc_evt || !in_set) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign en_sec     = tick;
    assign en_min     = in_run ? cd_sec : ((state == MODE_SET_MIN) && inc_evt);
    assign en_hour    = in_run ? cd_min : ((state == MODE_SET_HOUR) && inc_evt);
    assign en_day     = in_run && cd_hour;
    assign blink_hour = (state == MODE_SET_HOUR) && blink_phase;
    assign blink_min  = (state == MODE_SET_MIN) && blink_phase;
    assign mode       = state;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Randomized and directed bench for clock_mode_ctrl against a cycle-indexed
// reference model built from the button timing and mode rules.
module tb_clock_mode_ctrl;

    localparam int TICK_DIV    = 10;
    localparam int BLINK_DIV   = 4;
    localparam int REPEAT_DLY  = 8;
    localparam int REPEAT_RATE = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_mode;
    logic       btn_inc;
    logic       cd_sec;
    logic       cd_min;
    logic       cd_hour;
    logic       en_sec;
    logic       en_min;
    logic       en_hour;
    logic       en_day;
    logic       sec_clr;
    logic       blink_min;
    logic       blink_hour;
    logic [1:0] mode;

    wire [8:0] dut_out = {en_sec, en_min, en_hour, en_day, sec_clr, blink_min, blink_hour, mode};

    clock_mode_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .BLINK_DIV   (BLINK_DIV),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cd_sec     (cd_sec),
        .cd_min     (cd_min),
        .cd_hour    (cd_hour),
        .en_sec     (en_sec),
        .en_min     (en_min),
        .en_hour    (en_hour),
        .en_day     (en_day),
        .sec_clr    (sec_clr),
        .blink_min  (blink_min),
        .blink_hour (blink_hour),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: n counts clk edges since reset release; button samples are kept per edge.
    int         n;
    int         m;
    int         run_start;
    int         press_c;
    int         blink_start;
    bit         hold_valid;
    bit         sec_clr_m;
    bit         mode_smp [0:4095];
    bit         inc_smp  [0:4095];
    bit         mp;
    bit         ip;
    bit         lvl;
    bit         evt;
    logic [8:0] exp_out;

    function automatic bit smp_at(input bit is_inc, input int k);
        if (k < 1) return 1'b0;
        return is_inc ? inc_smp[k] : mode_smp[k];
    endfunction

    task automatic model_reset();
        n           = 0;
        m           = 0;
        run_start   = 0;
        press_c     = 0;
        blink_start = 0;
        hold_valid  = 1'b0;
        sec_clr_m   = 1'b0;
    endtask

    task automatic predict();
        bit rep;
        bit tick;
        bit phase;
        mp    = smp_at(1'b0, n - 2) && !smp_at(1'b0, n - 3);
        ip    = smp_at(1'b1, n - 2) && !smp_at(1'b1, n - 3);
        lvl   = smp_at(1'b1, n - 1);
        rep   = hold_valid && lvl && ((n - press_c) >= REPEAT_DLY) &&
                (((n - press_c - REPEAT_DLY) % REPEAT_RATE) == 0);
        evt   = (m != 0) && !mp && (ip || rep);
        tick  = (m == 0) && (((n - run_start) % TICK_DIV) == TICK_DIV - 1);
        phase = (((n - blink_start) / BLINK_DIV) % 2) == 1;
        exp_out = {tick,
                   (m == 0) ? cd_sec : ((m == 2) && evt),
                   (m == 0) ? cd_min : ((m == 1) && evt),
                   (m == 0) && cd_hour,
                   sec_clr_m,
                   (m == 2) && phase,
                   (m == 1) && phase,
                   2'(m)};
    endtask

    task automatic advance();
        if (mp || m == 0 || !lvl) begin
            hold_valid = 1'b0;
        end else if (ip) begin
            hold_valid = 1'b1;
            press_c    = n;
        end
        if (mp || evt) blink_start = n + 1;
        sec_clr_m = 1'b0;
        if (mp) begin
            sec_clr_m = (m == 0);
            m = (m + 1) % 3;
            if (m == 0) run_start = n + 1;
        end
        mode_smp[n + 1] = btn_mode;
        inc_smp[n + 1]  = btn_inc;
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic test_reset();
        int first_tick = -1;
        int ticks      = 0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cd_sec   = 1'b1;
        cd_min   = 1'b1;
        cd_hour  = 1'b1;
        reset_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (dut_out !== 9'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold got %b expected %b", dut_out, 9'b0);
        end
        cd_sec  = 1'b0;
        cd_min  = 1'b0;
        cd_hour = 1'b0;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            predict();
            #1;
            vectors++;
            if (dut_out !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL reset_idle n=%0d got %b expected %b", n, dut_out, exp_out);
            end
            if (en_sec) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
            end
            advance();
        end
        vectors++;
        if (first_tick !== TICK_DIV - 1) begin
            miscompares++;
            $display("[TB] FAIL first_tick got %0d expected %0d", first_tick, TICK_DIV - 1);
        end
        vectors++;
        if (ticks !== 3) begin
            miscompares++;
            $display("[TB] FAIL tick_count got %0d expected 3", ticks);
        end
    endtask

    task automatic test_run_carries();
        for (int i = 0; i < 40; i++) begin
            cd_sec  = 1'($urandom_range(0, 1));
            cd_min  = 1'($urandom_range(0, 1));
            cd_hour = 1'($urandom_range(0, 1));
            predict();
            #1;
            vectors++;
            if (dut_out !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL run_carries n=%0d got %b expected %b", n, dut_out, exp_out);
            end
            advance();
        end
    endtask

    task automatic test_set_hour();
        int clr_cnt  = 0;
        int sec_cnt  = 0;
        int hour_cnt = 0;
        int hour_at  = -1;
        int min_cnt  = 0;
        for (int i = 0; i < 55; i++) begin
            btn_mode = (i == 0);
            cd_sec   = 1'($urandom_range(0, 1));
            cd_min   = 1'($urandom_range(0, 1));
            cd_hour  = 1'($urandom_range(0, 1));
            predict();
            #1;
            vectors++;
            if (dut_out !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL enter_set_hour n=%0d got %b expected %b", n, dut_out, exp_out);
            end
            if (i >= 4) begin
                clr_cnt += int'(sec_clr);
                sec_cnt += int'(en_sec);
            end
            advance();
        end
        vectors++;
        if (clr_cnt !== 1 || sec_cnt !== 0) begin
            miscompares++;
            $display("[TB] FAIL set_hour_clr got clr=%0d sec=%0d expected clr=1 sec=0", clr_cnt, sec_cnt);
        end
        for (int i = 0; i < 15; i++) begin
            btn_inc = (i == 0);
            cd_sec  = 1'b1;
            cd_min  = 1'b1;
            cd_hour = 1'b1;
            predict();
            #1;
            vectors++;
            if (dut_out !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL hour_tap n=%0d got %b expected %b", n, dut_out, exp_out);
            end
            if (en_hour) begin
                hour_cnt++;
                if (hour_at < 0) hour_at = i;
            end
            min_cnt += int'(en_min) + int'(en_day);
            advance();
        end
        vectors++;
        if (hour_cnt !== 1 || hour_at !== 3 || min_cnt !== 0) begin
            miscompares++;
            $display("[TB] FAIL hour_tap_count got n=%0d at=%0d other=%0d expected n=1 at=3 other=0",
                     hour_cnt, hour_at, min_cnt);
        end
    endtask

    task automatic test_set_min_hold();
        int got[$];
        int want[6] = '{3, 11, 14, 17, 20, 23};
        for (int i = 0; i < 10; i++) begin
            btn_mode = (i == 0);
            btn_inc  = 1'b0;
            predict();
            #1;
            vectors++;
            if (dut_out !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL enter_set_min n=%0d got %b expected %b", n, dut_out, exp_out);
            end
            advance();
        end
        for (int i = 0; i < 45; i++) begin
            btn_inc = (i < 22);
            cd_sec  = 1'($urandom_range(0, 1));
            cd_min  = 1'($urandom_range(0, 1));
            cd_hour = 1'($urandom_range(0, 1));
            predict();
            #1;
            vectors++;
            if (dut_out !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL min_hold n=%0d got %b expected %b", n, dut_out, exp_out);
            end
            if (en_min) got.push_back(i);
            advance();
        end
        vectors++;
        if (got.size() !== 6) begin
            miscompares++;
            $display("[TB] FAIL repeat_count got %0d expected 6", got.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                vectors++;
                if (got[k] !== want[k]) begin
                    miscompares++;
                    $display("[TB] FAIL repeat_offset[%0d] got %0d expected %0d", k, got[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_sec = -1;
        for (int i = 0; i < 70; i++) begin
            btn_mode = (i == 0) || (i == 10) || (i == 20) || (i == 35);
            btn_inc  = (i == 20);
            cd_sec   = 1'($urandom_range(0, 1));
            cd_min   = 1'($urandom_range(0, 1));
            cd_hour  = 1'($urandom_range(0, 1));
            predict();
            #1;
            vectors++;
            if (dut_out !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL back_to_back n=%0d got %b expected %b", n, dut_out, exp_out);
            end
            if (i == 23) begin
                vectors++;
                if ({en_hour, en_min} !== 2'b00) begin
                    miscompares++;
                    $display("[TB] FAIL mode_wins_enable got %b expected 00", {en_hour, en_min});
                end
            end
            if (i == 24) begin
                vectors++;
                if (mode !== 2'b10) begin
                    miscompares++;
                    $display("[TB] FAIL mode_wins_state got %b expected 10", mode);
                end
            end
            if (i >= 39 && en_sec && first_sec < 0) first_sec = i;
            advance();
        end
        vectors++;
        if (first_sec !== 39 + TICK_DIV - 1) begin
            miscompares++;
            $display("[TB] FAIL rerun_first_tick got %0d expected %0d", first_sec, 39 + TICK_DIV - 1);
        end
    endtask

    task automatic test_blink_and_reset();
        int hour_blink = 0;
        int min_blink  = 0;
        for (int i = 0; i < 30; i++) begin
            btn_mode = (i == 0) || (i == 6);
            btn_inc  = 1'b0;
            cd_sec   = 1'b0;
            cd_min   = 1'b0;
            cd_hour  = 1'b0;
            predict();
            #1;
            vectors++;
            if (dut_out !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL blink n=%0d got %b expected %b", n, dut_out, exp_out);
            end
            if (i >= 10) begin
                hour_blink += int'(blink_hour);
                min_blink  += int'(blink_min);
            end
            advance();
        end
        vectors++;
        if (hour_blink !== 0 || min_blink !== 8) begin
            miscompares++;
            $display("[TB] FAIL blink_count got hour=%0d min=%0d expected hour=0 min=8", hour_blink, min_blink);
        end
        cd_sec  = 1'b1;
        cd_min  = 1'b1;
        cd_hour = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (dut_out !== 9'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset got %b expected %b", dut_out, 9'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        cd_sec  = 1'b0;
        cd_min  = 1'b0;
        cd_hour = 1'b0;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            predict();
            #1;
            vectors++;
            if (dut_out !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL after_reset n=%0d got %b expected %b", n, dut_out, exp_out);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) btn_inc = ~btn_inc;
            btn_mode = ($urandom_range(0, 29) == 0);
            cd_sec   = 1'($urandom_range(0, 1));
            cd_min   = 1'($urandom_range(0, 1));
            cd_hour  = 1'($urandom_range(0, 1));
            predict();
            #1;
            vectors++;
            if (dut_out !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL random n=%0d got %b expected %b", n, dut_out, exp_out);
            end
            advance();
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cd_sec   = 1'b0;
        cd_min   = 1'b0;
        cd_hour  = 1'b0;
        test_reset();
        test_run_carries();
        test_set_hour();
        test_set_min_hold();
        test_back_to_back();
        test_blink_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
